axi_read_responder: RTL
=======================

Name: axi_read_responder

Overview:
- AXI4 read-channel slave that answers single-beat reads issued by the spmv kernel's AXI read master.
- Accepts AR requests into an in-order queue and reads a local word-addressed RAM (1-cycle read latency).
- Returns R beats through a 2-entry output buffer, so rready backpressure never drops data.
- Used as the memory-side model/endpoint for spmv fetch paths, and as a bench responder for the master-side issue tracking.

Parameters:
- C_S_AXI_DATA_WIDTH, 64, rdata and RAM word width in bits; power of two, at least 8.
- C_S_AXI_ADDR_WIDTH, 32, araddr width in bits.
- MEM_DEPTH, 1024, RAM words; power of two.
- AR_DEPTH, 4, AR queue entries; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address ready.
- s_axi_araddr  in  C_S_AXI_ADDR_WIDTH  byte address.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  read data ready.
- s_axi_rdata  out  C_S_AXI_DATA_WIDTH  read data.
- s_axi_rresp  out  2  response code: 00 OKAY, 10 SLVERR.
- s_axi_rlast  out  1  constant 1; every response is a single beat.
- mem_wr_en  in  1  RAM preload write strobe.
- mem_wr_addr  in  log2(MEM_DEPTH)  RAM preload word index.
- mem_wr_data  in  C_S_AXI_DATA_WIDTH  RAM preload data.
- resp_idle  out  1  high when AR queue empty, no read in flight and R buffer empty.
- outstanding_cnt  out  log2(AR_DEPTH)+2  accepted ARs not yet retired on R.

Behaviour:
- Clock and reset: single clk; reset is synchronous and active-high (rst).
- Reset values:
  - s_axi_arready=0 during rst, 1 on the first cycle after rst deasserts.
  - s_axi_rvalid=0, s_axi_rresp=0, s_axi_rdata=0, outstanding_cnt=0, resp_idle=1.
  - All queues flushed.
  - RAM contents are NOT cleared by reset.
- AR accept:
  - s_axi_arready = ~rst & ~ar_full (registered full flag).
  - A handshake pushes araddr onto the AR queue.
  - No push when full; the arvalid/araddr holding requirement is on the master.
- Word index: araddr[log2(C_S_AXI_DATA_WIDTH/8) +: log2(MEM_DEPTH)]. Low byte-offset bits are ignored; upper bits are ignored unless the optional feature is enabled.
- Read issue:
  - Pop the queue head and read the RAM when the queue is non-empty and (reads in flight + R buffer occupancy) < 2 (credit rule).
  - Issue needs no state machine: one read per cycle maximum.
- Pipeline, single unloaded request:
  - AR handshake at edge T.
  - Read issued in cycle T+1.
  - s_axi_rvalid high from cycle T+2.
  - Minimum latency is 2 cycles.
- R channel:
  - The R buffer is a 2-entry FIFO.
  - rvalid = buffer non-empty; rdata/rresp are driven by the head entry.
  - rdata/rresp stay stable while rvalid & ~rready.
  - Pop on rvalid & rready.
  - Sustained throughput is 1 beat/cycle when rready is held high.
- Ordering: strictly in AR acceptance order; no IDs.
- outstanding_cnt:
  - +1 on AR handshake, -1 on R handshake.
  - Unchanged when both happen in the same cycle.
  - Never exceeds AR_DEPTH+2.
- RAM collision: a preload write and a read of the same index in the same cycle return OLD data (read-first).
- Boundaries:
  - Full queue: arready low; it rises the cycle after a pop.
  - Queue pointers wrap modulo AR_DEPTH.
  - rready held low: at most 2 beats buffered, then issue stalls and the queue fills to AR_DEPTH, then arready drops.
- Reset mid-operation: in-flight reads and buffered beats are discarded; rvalid is 0 in the cycle after rst is sampled.

Optional Feature:
- Macro: AXI_RD_RANGE_CHECK_EN.
- Defined:
  - Any request whose word address (araddr >> log2(C_S_AXI_DATA_WIDTH/8)) >= MEM_DEPTH returns rresp=2'b10 (SLVERR) with rdata=0.
  - The request still consumes a queue slot and keeps its order.
- Undefined: the address silently wraps modulo MEM_DEPTH; rresp is always 2'b00.

Test Plan:
- Reset release: preload word 5 = 64'hDEAD_BEEF_0000_0005; AR araddr=0x28 at edge T with rready=1 -> rvalid at T+2, rdata=64'hDEAD_BEEF_0000_0005, rresp=0, rlast=1; outstanding_cnt 1 then 0; resp_idle back to 1.
- Streaming: preload words 0..7 = index value; issue 8 back-to-back ARs (0x00,0x08,...,0x38) with rready=1 -> 8 consecutive rvalid cycles returning data 0..7 in order, no bubbles after the first.
- Backpressure: AR_DEPTH=4, rready=0, issue 8 ARs -> exactly 6 accepted, arready low afterwards, outstanding_cnt=6; rdata constant while stalled; raise rready -> remaining 2 accepted, all 8 returned in order.
- Collision: in the same cycle, a preload write to word 3 with 64'h1111 and a read issued to word 3 (old value 64'h2222) -> returns 64'h2222; a subsequent read of word 3 returns 64'h1111.
- Mid-op reset: 3 ARs outstanding, rready=0, pulse rst for 1 cycle -> rvalid=0 and outstanding_cnt=0 next cycle; new AR afterwards completes normally with 2-cycle latency.
- Range check with AXI_RD_RANGE_CHECK_EN, MEM_DEPTH=1024: araddr=0x2000 (word 1024) -> rresp=2'b10, rdata=0; without the macro -> rresp=0, data of word 0.

Source files
------------

// File: rtl/axi_read_responder.sv
// ---------------------------------------------------------------------------
// axi_read_responder
//
// Purpose:
//   AXI4 read-channel slave that answers single-beat reads. Accepted AR
//   addresses go into an in-order queue. The head of the queue reads a local
//   word-addressed RAM. The RAM result is written straight into a 2-entry R
//   buffer, so rready backpressure never drops a beat. Responses come back
//   strictly in AR acceptance order.
//
// Optional feature (compile-time macro):
//   AXI_RD_RANGE_CHECK_EN
//     - Defined: a request whose word address is at or beyond MEM_DEPTH
//       returns SLVERR (rresp=2'b10) with rdata=0. The request still takes a
//       queue slot and keeps its place in the response order.
//     - Undefined: the upper address bits are ignored, so the index wraps
//       modulo MEM_DEPTH, and rresp is always OKAY.
//
// Ports:
//   clk, rst          - clock; synchronous active-high reset
//   s_axi_arvalid/ready/araddr
//                     - read address channel (byte address)
//   s_axi_rvalid/ready/rdata/rresp/rlast
//                     - read data channel (single beat, rlast tied high)
//   mem_wr_en/addr/data
//                     - RAM preload write port (word index)
//   resp_idle         - nothing queued, in flight or buffered
//   outstanding_cnt   - accepted ARs not yet retired on R
// ---------------------------------------------------------------------------
module axi_read_responder #(
  parameter int C_S_AXI_DATA_WIDTH = 64,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int MEM_DEPTH          = 1024,
  parameter int AR_DEPTH           = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rlast,
  input  logic                          mem_wr_en,
  input  logic [$clog2(MEM_DEPTH)-1:0]  mem_wr_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] mem_wr_data,
  output logic                          resp_idle,
  output logic [$clog2(AR_DEPTH)+1:0]   outstanding_cnt
);

  localparam int OFFS = $clog2(C_S_AXI_DATA_WIDTH / 8);
  localparam int IDXW = $clog2(MEM_DEPTH);
  localparam int PTRW = $clog2(AR_DEPTH);
  localparam int CNTW = PTRW + 2;
  localparam logic [PTRW:0] AR_FULL_LVL = (PTRW + 1)'(AR_DEPTH);

  // Local RAM; never cleared by reset.
  logic [C_S_AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // AR queue: word index plus an out-of-range flag for each entry.
  logic [IDXW-1:0] arIdx_q [AR_DEPTH];
  logic            arErr_q [AR_DEPTH];
  logic [PTRW-1:0] arWrPtr_q, arWrPtr_d;
  logic [PTRW-1:0] arRdPtr_q, arRdPtr_d;
  logic [PTRW:0]   arCount_q, arCount_d;
  logic            arFull_q, arFull_d;

  // R buffer: 2-entry FIFO holding the completed RAM reads.
  logic [C_S_AXI_DATA_WIDTH-1:0] rbData_q [2];
  logic [1:0]                    rbResp_q [2];
  logic                          rbWrPtr_q, rbWrPtr_d;
  logic                          rbRdPtr_q, rbRdPtr_d;
  logic [1:0]                    rbCount_q, rbCount_d;

  logic [CNTW-1:0] outCnt_q, outCnt_d;

  logic            arPush;
  logic            rdIssue;
  logic            rPop;
  logic [IDXW-1:0] reqIdx;
  logic            reqErr;
  logic [IDXW-1:0] issIdx;
  logic            issErr;
  logic            unusedAddrBits;

  // The byte-offset bits (and, without the range check, the upper bits) of
  // araddr carry no meaning here. They are folded into a sink so that all
  // address bits are consumed.
  assign unusedAddrBits = ^s_axi_araddr;

  assign reqIdx = s_axi_araddr[OFFS +: IDXW];

`ifdef AXI_RD_RANGE_CHECK_EN
  // Any set bit above the RAM index field puts the word address past the RAM.
  assign reqErr = |(s_axi_araddr >> (OFFS + IDXW));
`else
  assign reqErr = 1'b0;
`endif

  // arready depends only on the registered full flag, so it has no
  // combinational path from arvalid.
  assign s_axi_arready = ~rst & ~arFull_q;
  assign arPush        = s_axi_arvalid & s_axi_arready;

  // A RAM read lands directly in the R buffer at the clock edge, so no read
  // is ever left pending between cycles. The credit check therefore reduces
  // to the buffer occupancy. Same-cycle pops are deliberately not counted,
  // which keeps the issue path free of rready.
  assign rdIssue = (arCount_q != '0) && (rbCount_q != 2'd2);
  assign issIdx  = arIdx_q[arRdPtr_q];
  assign issErr  = arErr_q[arRdPtr_q];

  assign s_axi_rvalid = (rbCount_q != 2'd0);
  assign rPop         = s_axi_rvalid & s_axi_rready;
  assign s_axi_rdata  = rbData_q[rbRdPtr_q];
  assign s_axi_rresp  = rbResp_q[rbRdPtr_q];
  assign s_axi_rlast  = 1'b1;

  assign resp_idle       = (arCount_q == '0) && (rbCount_q == 2'd0);
  assign outstanding_cnt = outCnt_q;

  // AR queue bookkeeping. The pointers wrap naturally because AR_DEPTH is a
  // power of two. The full flag is computed from the next count so that it
  // is registered.
  always_comb begin
    arWrPtr_d = arWrPtr_q;
    arRdPtr_d = arRdPtr_q;
    arCount_d = arCount_q;
    if (arPush) begin
      arWrPtr_d = arWrPtr_q + 1'b1;
    end
    if (rdIssue) begin
      arRdPtr_d = arRdPtr_q + 1'b1;
    end
    case ({arPush, rdIssue})
      2'b10:   arCount_d = arCount_q + 1'b1;
      2'b01:   arCount_d = arCount_q - 1'b1;
      default: arCount_d = arCount_q;
    endcase
    arFull_d = (arCount_d == AR_FULL_LVL);
  end

  // R buffer bookkeeping and the outstanding-transaction counter.
  always_comb begin
    rbWrPtr_d = rbWrPtr_q ^ rdIssue;
    rbRdPtr_d = rbRdPtr_q ^ rPop;
    case ({rdIssue, rPop})
      2'b10:   rbCount_d = rbCount_q + 1'b1;
      2'b01:   rbCount_d = rbCount_q - 1'b1;
      default: rbCount_d = rbCount_q;
    endcase
    case ({arPush, rPop})
      2'b10:   outCnt_d = outCnt_q + 1'b1;
      2'b01:   outCnt_d = outCnt_q - 1'b1;
      default: outCnt_d = outCnt_q;
    endcase
  end

  // Control state. Reset flushes both queues by clearing their pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      arWrPtr_q <= '0;
      arRdPtr_q <= '0;
      arCount_q <= '0;
      arFull_q  <= 1'b0;
      rbWrPtr_q <= 1'b0;
      rbRdPtr_q <= 1'b0;
      rbCount_q <= 2'd0;
      outCnt_q  <= '0;
    end else begin
      arWrPtr_q <= arWrPtr_d;
      arRdPtr_q <= arRdPtr_d;
      arCount_q <= arCount_d;
      arFull_q  <= arFull_d;
      rbWrPtr_q <= rbWrPtr_d;
      rbRdPtr_q <= rbRdPtr_d;
      rbCount_q <= rbCount_d;
      outCnt_q  <= outCnt_d;
    end
  end

  // AR queue payload. Entries are only meaningful between the pointers, so
  // this storage needs no reset.
  always_ff @(posedge clk) begin
    if (arPush) begin
      arIdx_q[arWrPtr_q] <= reqIdx;
      arErr_q[arWrPtr_q] <= reqErr;
    end
  end

  // Preload write port. The RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_wr_addr] <= mem_wr_data;
    end
  end

  // RAM read into the R buffer. A preload write to the same word on the same
  // edge is not yet visible here, so the read returns the old data
  // (read-first). Entries are cleared on reset so that rdata/rresp read as
  // zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rbData_q[0] <= '0;
      rbData_q[1] <= '0;
      rbResp_q[0] <= 2'b00;
      rbResp_q[1] <= 2'b00;
    end else if (rdIssue) begin
      rbData_q[rbWrPtr_q] <= issErr ? '0 : mem[issIdx];
      rbResp_q[rbWrPtr_q] <= issErr ? 2'b10 : 2'b00;
    end
  end

endmodule
